// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler: walks the butterfly array through all LOG_N NTT stages.
// Each stage issues BEATS coefficient-RAM read beats (twiddle index = beat), then
// drains for L = RD_LAT + BF_LAT cycles so the last write-back lands before the
// next stage reads. Write-back strobe/address/stage come from an L-deep delay line.
// Optional feature: define NTT_SCHED_PERF_EN to add the perf_cycles_o counter.
module ntt_stage_scheduler #(
   parameter int unsigned N      = 2048,
   parameter int unsigned P      = 128,
   parameter int unsigned LOG_N  = 11,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned BF_LAT = 8,
   parameter int unsigned AW     = 3,
   parameter int unsigned TW     = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          abort_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [3:0]    stage_o,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   output logic [TW-1:0] tw_idx_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [3:0]    wr_stage_o
`ifdef NTT_SCHED_PERF_EN
   ,
   output logic [15:0]   perf_cycles_o
`endif
);

   localparam int unsigned BEATS = N / (2 * P);
   localparam int unsigned L     = RD_LAT + BF_LAT;
   localparam int unsigned DW    = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] beat_q, beat_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [3:0]    stage_q, stage_d;
   logic          clear_pipe;
   logic          busy;

   logic [L-1:0]  pipe_en_q;
   logic [AW-1:0] pipe_addr_q  [L];
   logic [3:0]    pipe_stage_q [L];

   // Next-state logic for the stage/beat/drain sequencer; abort overrides all.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      drain_d    = drain_q;
      stage_d    = stage_q;
      clear_pipe = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               state_d = StIssue;
               beat_d  = '0;
               stage_d = '0;
            end
         end
         StIssue: begin
            if (beat_q == AW'(BEATS - 1)) begin
               state_d = StDrain;
               beat_d  = '0;
               drain_d = DW'(L - 1);
            end else begin
               beat_d = beat_q + AW'(1);
            end
         end
         StDrain: begin
            if (drain_q == '0) begin
               if (stage_q == 4'(LOG_N - 1)) begin
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
                  stage_d = stage_q + 4'd1;
                  beat_d  = '0;
               end
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Abort is a no-op in IDLE so a finished transform keeps its final stage.
      if (abort_i && (state_q != StIdle)) begin
         state_d    = StIdle;
         beat_d     = '0;
         drain_d    = '0;
         stage_d    = '0;
         clear_pipe = 1'b1;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         beat_q  <= '0;
         drain_q <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
         stage_q <= stage_d;
      end
   end

   // Write-back delay line: shifts every cycle so writes trail reads by exactly L.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_en_q <= '0;
         for (int i = 0; i < L; i++) begin
            pipe_addr_q[i]  <= '0;
            pipe_stage_q[i] <= '0;
         end
      end else if (clear_pipe) begin
         pipe_en_q <= '0;
         for (int i = 0; i < L; i++) begin
            pipe_addr_q[i]  <= '0;
            pipe_stage_q[i] <= '0;
         end
      end else begin
         pipe_en_q[0]    <= rd_en_o;
         pipe_addr_q[0]  <= rd_addr_o;
         pipe_stage_q[0] <= stage_q;
         for (int i = 1; i < L; i++) begin
            pipe_en_q[i]    <= pipe_en_q[i-1];
            pipe_addr_q[i]  <= pipe_addr_q[i-1];
            pipe_stage_q[i] <= pipe_stage_q[i-1];
         end
      end
   end

   // Moore outputs; beat_q is zero outside ISSUE so read address needs no gating.
   always_comb begin
      busy       = (state_q == StIssue) || (state_q == StDrain);
      busy_o     = busy;
      done_o     = (state_q == StDone);
      stage_o    = stage_q;
      rd_en_o    = (state_q == StIssue);
      rd_addr_o  = beat_q;
      tw_idx_o   = TW'(beat_q);
      wr_en_o    = pipe_en_q[L-1];
      wr_addr_o  = pipe_addr_q[L-1];
      wr_stage_o = pipe_stage_q[L-1];
   end

`ifdef NTT_SCHED_PERF_EN
   logic [15:0] perf_q;

   // Busy-cycle counter: cleared on launch, held once the transform stops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if ((state_q == StIdle) && (state_d == StIssue)) begin
         perf_q <= '0;
      end else if (busy) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// tb_ntt_stage_scheduler: directed scenarios plus random start/abort traffic,
// checked every cycle against a timeline model of the transform.
module tb_ntt_stage_scheduler;

   localparam int BEATS  = 8;
   localparam int L      = 9;
   localparam int LOG_N  = 11;
   localparam int PERIOD = BEATS + L;
   localparam int TOTAL  = LOG_N * PERIOD;

   logic       clk = 1'b0;
   logic       rst_n, start, abort;
   logic       busy, done, rd_en, wr_en;
   logic [3:0] stage, wr_stage, tw_idx;
   logic [2:0] rd_addr, wr_addr;
`ifdef NTT_SCHED_PERF_EN
   logic [15:0] perf;
`endif

   ntt_stage_scheduler dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .busy_o     (busy),
      .done_o     (done),
      .stage_o    (stage),
      .rd_en_o    (rd_en),
      .rd_addr_o  (rd_addr),
      .tw_idx_o   (tw_idx),
      .wr_en_o    (wr_en),
      .wr_addr_o  (wr_addr),
      .wr_stage_o (wr_stage)
`ifdef NTT_SCHED_PERF_EN
      ,
      .perf_cycles_o (perf)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: m_k = cycles since first read of the running transform (-1 idle,
   // TOTAL = the done cycle); history arrays hold the read side L cycles back.
   int m_k;
   int m_stage;
   int m_perf;
   int h_en [L];
   int h_addr [L];
   int h_stage [L];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_busy();
      return (m_k >= 0 && m_k < TOTAL) ? 1 : 0;
   endfunction

   function automatic int m_rd();
      return (m_busy() == 1 && (m_k % PERIOD) < BEATS) ? 1 : 0;
   endfunction

   function automatic int m_addr();
      return (m_rd() == 1) ? (m_k % PERIOD) : 0;
   endfunction

   task automatic model_reset();
      m_k = -1;
      m_stage = 0;
      m_perf = 0;
      for (int i = 0; i < L; i++) begin
         h_en[i] = 0;
         h_addr[i] = 0;
         h_stage[i] = 0;
      end
   endtask

   task automatic hist_push(input int en, input int addr, input int stg);
      for (int i = L - 1; i > 0; i--) begin
         h_en[i] = h_en[i-1];
         h_addr[i] = h_addr[i-1];
         h_stage[i] = h_stage[i-1];
      end
      h_en[0] = en;
      h_addr[0] = addr;
      h_stage[0] = stg;
   endtask

   // Advance the model across one rising edge using the inputs seen there.
   task automatic model_edge();
      int pb, pr, pa, ps;
      pb = m_busy();
      pr = m_rd();
      pa = m_addr();
      ps = m_stage;
      if (m_k < 0) begin
         hist_push(pr, pa, ps);
         if (start && !abort) begin
            m_k = 0;
            m_stage = 0;
            m_perf = 0;
         end
      end else if (abort) begin
         if (pb == 1) m_perf = (m_perf + 1) & 16'hFFFF;
         m_k = -1;
         m_stage = 0;
         for (int i = 0; i < L; i++) begin
            h_en[i] = 0;
            h_addr[i] = 0;
            h_stage[i] = 0;
         end
      end else begin
         hist_push(pr, pa, ps);
         if (pb == 1) m_perf = (m_perf + 1) & 16'hFFFF;
         m_k++;
         if (m_k > TOTAL) m_k = -1;
         else if (m_k < TOTAL) m_stage = m_k / PERIOD;
      end
   endtask

   task automatic compare_all();
      chk("busy", int'(busy), m_busy());
      chk("done", int'(done), (m_k == TOTAL) ? 1 : 0);
      chk("stage", int'(stage), m_stage);
      chk("rd_en", int'(rd_en), m_rd());
      chk("rd_addr", int'(rd_addr), m_addr());
      chk("tw_idx", int'(tw_idx), m_addr());
      chk("wr_en", int'(wr_en), h_en[L-1]);
      chk("wr_addr", int'(wr_addr), h_addr[L-1]);
      chk("wr_stage", int'(wr_stage), h_stage[L-1]);
`ifdef NTT_SCHED_PERF_EN
      chk("perf", int'(perf), m_perf);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic chk_perf_lit(input string name, input int exp);
`ifdef NTT_SCHED_PERF_EN
      chk(name, int'(perf), exp);
`else
      if (exp < 0) chk(name, 0, 1);
`endif
   endtask

   // Hand-computed timeline of a single clean transform launched at cycle 0.
   task automatic lit_run(input int c);
      if (c == 1) begin
         chk("lit_rd_en_c1", int'(rd_en), 1);
         chk("lit_rd_addr_c1", int'(rd_addr), 0);
         chk("lit_busy_c1", int'(busy), 1);
      end
      if (c == 8) begin
         chk("lit_rd_addr_c8", int'(rd_addr), 7);
         chk("lit_tw_idx_c8", int'(tw_idx), 7);
      end
      if (c == 9) chk("lit_rd_en_c9", int'(rd_en), 0);
      if (c == 9) chk("lit_wr_en_c9", int'(wr_en), 0);
      if (c == 10) begin
         chk("lit_wr_en_c10", int'(wr_en), 1);
         chk("lit_wr_addr_c10", int'(wr_addr), 0);
      end
      if (c == 17) begin
         chk("lit_wr_en_c17", int'(wr_en), 1);
         chk("lit_wr_addr_c17", int'(wr_addr), 7);
      end
      if (c == 18) begin
         chk("lit_stage_c18", int'(stage), 1);
         chk("lit_rd_en_c18", int'(rd_en), 1);
         chk("lit_wr_en_c18", int'(wr_en), 0);
      end
      if (c == 187) chk("lit_busy_c187", int'(busy), 1);
      if (c == 188) begin
         chk("lit_done_c188", int'(done), 1);
         chk("lit_busy_c188", int'(busy), 0);
         chk_perf_lit("lit_perf_c188", 187);
      end
      if (c == 189) begin
         chk("lit_done_c189", int'(done), 0);
         chk("lit_stage_c189", int'(stage), 10);
      end
   endtask

   initial begin
      int c, busy_cnt, dones, wr_seen, done_seen;
      model_reset();
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #12;
      compare_all();
      rst_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_busy", int'(busy), 0);
      end

      // Single clean transform.
      start = 1'b1;
      step();
      start = 1'b0;
      c = 1;
      busy_cnt = int'(busy);
      lit_run(c);
      while (c < 190) begin
         step();
         c++;
         busy_cnt += int'(busy);
         lit_run(c);
      end
      chk("busy_cycles", busy_cnt, 187);

      // Start held high: one transform, next launch two cycles after done.
      start = 1'b1;
      step();
      c = 1;
      dones = 0;
      while (c < 195) begin
         step();
         c++;
         if (c <= 189 && done) dones++;
         if (c == 188) chk("held_done_c188", int'(done), 1);
         if (c == 189) chk("held_rd_en_c189", int'(rd_en), 0);
         if (c == 190) begin
            chk("held_rd_en_c190", int'(rd_en), 1);
            chk("held_stage_c190", int'(stage), 0);
         end
      end
      chk("held_done_count", dones, 1);
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // Abort at stage 3, beat 5.
      start = 1'b1;
      step();
      start = 1'b0;
      c = 1;
      while (c < 1 + 3 * PERIOD + 5) begin
         step();
         c++;
      end
      chk("abort_pre_stage", int'(stage), 3);
      chk("abort_pre_beat", int'(rd_addr), 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_stage", int'(stage), 0);
      wr_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         wr_seen += int'(wr_en);
         done_seen += int'(done);
      end
      chk("abort_no_wr", wr_seen, 0);
      chk("abort_no_done", done_seen, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_stage", int'(stage), 0);
      chk("restart_rd_en", int'(rd_en), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // Async reset in stage 6 drain, then a full run.
      start = 1'b1;
      step();
      start = 1'b0;
      c = 1;
      while (c < 1 + 6 * PERIOD + BEATS + 3) begin
         step();
         c++;
      end
      chk("rst_pre_stage", int'(stage), 6);
      chk("rst_pre_drain", int'(rd_en), 0);
      chk("rst_pre_wr_en", int'(wr_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_stage", int'(wr_stage), 0);
      chk_perf_lit("rst_perf", 0);
      #3;
      rst_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      c = 1;
      lit_run(c);
      while (c < 190) begin
         step();
         c++;
         lit_run(c);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         chk_perf_lit("perf_hold", 187);
      end

      // Random start/abort traffic.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 249) == 0);
         step();
      end
      start = 1'b0;
      abort = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
